// File: rtl/encoder_position_tracker.sv
// rtl/encoder_position_tracker.sv - quadrature direction to position/velocity tracker
// Optional macro ENCODER_POS_SAT_EN: saturate pos instead of wrapping.
module encoder_position_tracker #(
    parameter int POS_W      = 16,
    parameter int VEL_W      = 8,
    parameter int WIN_CYCLES = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       dir,
    input  logic             clear,
    output logic [POS_W-1:0] pos,
    output logic [VEL_W-1:0] vel,
    output logic             vel_valid,
    output logic             err
);

    localparam int CNT_W = (WIN_CYCLES > 2) ? $clog2(WIN_CYCLES) : 1;

    localparam logic [POS_W-1:0]        POS_ONE = {{(POS_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]        CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(WIN_CYCLES - 1);
    localparam logic signed [VEL_W:0]   ACC_ONE = {{VEL_W{1'b0}}, 1'b1};
    localparam logic signed [VEL_W:0]   ACC_MAX = {1'b0, {VEL_W{1'b1}}};
    localparam logic signed [VEL_W:0]   ACC_MIN = {1'b1, {VEL_W{1'b0}}};
    localparam logic signed [VEL_W:0]   VEL_MAX = {2'b00, {(VEL_W-1){1'b1}}};
    localparam logic signed [VEL_W:0]   VEL_MIN = {2'b11, {(VEL_W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_FWD  = 2'b01,
        S_REV  = 2'b10
    } state_t;

    state_t                  r_state;
    logic [POS_W-1:0]        r_pos;
    logic [VEL_W-1:0]        r_vel;
    logic                    r_vel_valid;
    logic                    r_err;
    logic signed [VEL_W:0]   r_acc;
    logic [CNT_W-1:0]        r_win;

    logic                    w_illegal;
    logic                    w_up;
    logic                    w_dn;
    logic                    w_close;
    logic signed [VEL_W:0]   w_acc_next;
    logic [VEL_W-1:0]        w_vel_sat;
    logic [POS_W-1:0]        w_pos_next;

    // A step is an entry into FWD or REV; dir==11 matches neither.
    assign w_illegal = (dir == 2'b11);
    assign w_up      = (dir == 2'b01) && (r_state != S_FWD);
    assign w_dn      = (dir == 2'b10) && (r_state != S_REV);
    assign w_close   = (r_win == CNT_LAST);

    always_comb begin
        w_acc_next = r_acc;
        if (w_up && (r_acc != ACC_MAX)) begin
            w_acc_next = r_acc + ACC_ONE;
        end else if (w_dn && (r_acc != ACC_MIN)) begin
            w_acc_next = r_acc - ACC_ONE;
        end
    end

    always_comb begin
        w_vel_sat = w_acc_next[VEL_W-1:0];
        if (w_acc_next > VEL_MAX) begin
            w_vel_sat = VEL_MAX[VEL_W-1:0];
        end else if (w_acc_next < VEL_MIN) begin
            w_vel_sat = VEL_MIN[VEL_W-1:0];
        end
    end

`ifdef ENCODER_POS_SAT_EN
    localparam logic [POS_W-1:0] POS_MAX = {1'b0, {(POS_W-1){1'b1}}};
    localparam logic [POS_W-1:0] POS_MIN = {1'b1, {(POS_W-1){1'b0}}};

    always_comb begin
        w_pos_next = r_pos;
        if (w_up && (r_pos != POS_MAX)) begin
            w_pos_next = r_pos + POS_ONE;
        end else if (w_dn && (r_pos != POS_MIN)) begin
            w_pos_next = r_pos - POS_ONE;
        end
    end
`else
    always_comb begin
        w_pos_next = r_pos;
        if (w_up) begin
            w_pos_next = r_pos + POS_ONE;
        end else if (w_dn) begin
            w_pos_next = r_pos - POS_ONE;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_pos       <= '0;
            r_vel       <= '0;
            r_vel_valid <= 1'b0;
            r_err       <= 1'b0;
            r_acc       <= '0;
            r_win       <= '0;
        end else if (clear) begin
            r_state     <= S_IDLE;
            r_pos       <= '0;
            r_vel_valid <= 1'b0;
            r_acc       <= '0;
            r_win       <= '0;
        end else begin
            if (w_illegal) begin
                r_err <= 1'b1;
            end else begin
                r_state <= state_t'(dir);
            end
            r_pos <= w_pos_next;
            // The closing cycle's own step is folded into the reported window.
            if (w_close) begin
                r_vel       <= w_vel_sat;
                r_vel_valid <= 1'b1;
                r_acc       <= '0;
                r_win       <= '0;
            end else begin
                r_vel_valid <= 1'b0;
                r_acc       <= w_acc_next;
                r_win       <= r_win + CNT_ONE;
            end
        end
    end

    assign pos       = r_pos;
    assign vel       = r_vel;
    assign vel_valid = r_vel_valid;
    assign err       = r_err;

endmodule
